// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issues M-extension ops from EX to the multi-cycle mul/div unit,
// stalls the front end until completion, handles flushes and a completion watchdog.
module muldiv_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_muldiv,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_rs1,
  input  logic [DATA_W-1:0] ex_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  output logic              stall,
  output logic              md_valid,
  output logic [2:0]        md_op,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_div_by_zero,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_dbz,
  output logic              timeout_err
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              wdbz_q, wdbz_d, terr_q, terr_d;
  logic              req, expired;

  assign req     = ex_valid & ex_is_muldiv & ~flush;
  assign expired = (cnt_q == CW'(TIMEOUT - 1)) & ~md_done;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    wdbz_d  = wdbz_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = ISSUE;
        op_d    = ex_op;
        a_d     = ex_rs1;
        b_d     = ex_rs2;
        rd_d    = ex_rd;
      end
      ISSUE: state_d = flush ? DRAIN : WAIT;
      WAIT: if (md_done) begin
        state_d = flush ? IDLE : DONE;
        wdata_d = flush ? wdata_q : md_result;
        wdbz_d  = flush ? wdbz_q : md_div_by_zero;
      end else if (flush) begin
        state_d = DRAIN;
      end else if (expired) begin
        state_d = DONE;
        wdata_d = '0;
        wdbz_d  = 1'b0;
        terr_d  = 1'b1;
      end
      DONE: state_d = IDLE;
      DRAIN: if (md_done | expired) begin
        state_d = IDLE;
        terr_d  = terr_q | expired;
      end
      default: state_d = IDLE;
    endcase
  end

  // the watchdog restarts on every entry to WAIT or DRAIN, including WAIT->DRAIN
  assign cnt_d = (state_d == state_q && (state_q == WAIT || state_q == DRAIN)) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      wdbz_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      wdbz_q  <= wdbz_d;
      terr_q  <= terr_d;
    end
  end

  assign stall       = (state_q == IDLE & req) | state_q == ISSUE | state_q == WAIT |
                       (state_q == DRAIN & ex_valid & ex_is_muldiv);
  assign md_valid    = state_q == ISSUE;
  assign md_op       = op_q;
  assign md_a        = a_q;
  assign md_b        = b_q;
  assign wb_valid    = state_q == DONE & ~flush;
  assign wb_rd       = rd_q;
  assign wb_data     = wdata_q;
  assign wb_dbz      = wdbz_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: directed vector table, hand-written watchdog/reset sequences and
// a randomized run against a transaction-level reference model with a fake mul/div unit.
module tb_muldiv_issue_ctrl;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid = 0, ex_is_muldiv = 0, flush = 0, md_done = 0, md_div_by_zero = 0;
  logic [2:0] ex_op = 0;
  logic [DW-1:0] ex_rs1 = 0, ex_rs2 = 0, md_result = 0;
  logic [4:0] ex_rd = 0;
  logic stall, md_valid, wb_valid, wb_dbz, timeout_err;
  logic [2:0] md_op;
  logic [DW-1:0] md_a, md_b, wb_data;
  logic [4:0] wb_rd;
  int checks = 0, errors = 0;

  muldiv_issue_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_muldiv(ex_is_muldiv), .ex_op(ex_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush), .stall(stall),
    .md_valid(md_valid), .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_done(md_done),
    .md_result(md_result), .md_div_by_zero(md_div_by_zero), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_dbz(wb_dbz), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef struct {
    logic v, m; logic [2:0] op; logic [31:0] rs1, rs2; logic [4:0] rd;
    logic fl, dn; logic [31:0] res; logic dz;
    logic e_stall, e_mdv, e_wbv; logic [31:0] e_a, e_b; logic [2:0] e_op;
    logic [31:0] e_wd; logic [4:0] e_rd; logic e_dz;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic fl, input logic dn,
                       input logic [31:0] res, input logic dz);
    ex_valid = v; ex_is_muldiv = m; ex_op = op; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    flush = fl; md_done = dn; md_result = res; md_div_by_zero = dz;
  endtask

  // RISC-V M-extension semantics; returns {div_by_zero, result}
  function automatic logic [32:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, p;
    logic signed [31:0] x, y;
    logic [31:0] r;
    logic ovf;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    x = a; y = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * {32'd0, b}; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(x / y);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(x % y);
      default: r = (b == 0) ? a : a % b;
    endcase
    return {op[2] && (b == 0), r};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] sp[4];
    sp[0] = 32'h8000_0000; sp[1] = 32'hFFFF_FFFF; sp[2] = 32'd0; sp[3] = 32'd1;
    return ($urandom % 4 == 0) ? sp[$urandom % 4] : $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int mv, wc, got, udue, lat;
    logic [31:0] ures;
    logic udz;
    logic m_cap, m_out, m_doom, m_wb, m_terr, m_dz, m_wdz, m_req, m_idle, e_stall;
    logic [2:0] m_op;
    logic [31:0] m_a, m_b, m_res, m_wd;
    logic [4:0] m_rd;
    int m_t;

    // v m op rs1 rs2 rd | fl dn res dz | stall mdv wbv | a b op | wd rd dz
    tbl[0]  = '{1,1,5,100,7,9, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[1]  = '{1,1,5,100,7,9, 0,0,0,0, 1,1,0, 100,7,5, 0,0,0};
    tbl[2]  = '{1,1,5,100,7,9, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[3]  = '{1,1,5,100,7,9, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[4]  = '{1,1,5,100,7,9, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[5]  = '{1,1,5,100,7,9, 0,1,14,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[6]  = '{1,1,5,100,7,9, 0,0,0,0, 0,0,1, 0,0,0, 14,9,0};
    tbl[7]  = '{1,1,4,123,0,3, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[8]  = '{1,1,4,123,0,3, 0,0,0,0, 1,1,0, 123,0,4, 0,0,0};
    tbl[9]  = '{1,1,4,123,0,3, 0,1,32'hFFFF_FFFF,1, 1,0,0, 0,0,0, 0,0,0};
    tbl[10] = '{1,1,4,123,0,3, 0,0,0,0, 0,0,1, 0,0,0, 32'hFFFF_FFFF,3,1};
    tbl[11] = '{1,1,0,6,7,4, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[12] = '{1,1,0,6,7,4, 0,0,0,0, 1,1,0, 6,7,0, 0,0,0};
    tbl[13] = '{1,1,0,6,7,4, 1,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[14] = '{0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0};
    tbl[15] = '{1,1,0,3,5,8, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[16] = '{1,1,0,3,5,8, 0,1,42,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[17] = '{1,1,0,3,5,8, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[18] = '{1,1,0,3,5,8, 0,0,0,0, 1,1,0, 3,5,0, 0,0,0};
    tbl[19] = '{1,1,0,3,5,8, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[20] = '{1,1,0,3,5,8, 1,1,15,0, 1,0,0, 0,0,0, 0,0,0};
    tbl[21] = '{0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0};
    tbl[22] = '{0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0};

    #3;
    chk("rst_stall", 64'(stall), 0);       chk("rst_md_valid", 64'(md_valid), 0);
    chk("rst_md_op", 64'(md_op), 0);       chk("rst_md_a", 64'(md_a), 0);
    chk("rst_md_b", 64'(md_b), 0);         chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_wb_rd", 64'(wb_rd), 0);       chk("rst_wb_data", 64'(wb_data), 0);
    chk("rst_wb_dbz", 64'(wb_dbz), 0);     chk("rst_timeout_err", 64'(timeout_err), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].v, tbl[i].m, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].fl, tbl[i].dn, tbl[i].res, tbl[i].dz);
      @(negedge clk);
      chk($sformatf("t%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
      chk($sformatf("t%0d_md_valid", i), 64'(md_valid), 64'(tbl[i].e_mdv));
      chk($sformatf("t%0d_wb_valid", i), 64'(wb_valid), 64'(tbl[i].e_wbv));
      if (tbl[i].e_mdv) begin
        chk($sformatf("t%0d_md_a", i), 64'(md_a), 64'(tbl[i].e_a));
        chk($sformatf("t%0d_md_b", i), 64'(md_b), 64'(tbl[i].e_b));
        chk($sformatf("t%0d_md_op", i), 64'(md_op), 64'(tbl[i].e_op));
      end
      if (tbl[i].e_wbv) begin
        chk($sformatf("t%0d_wb_data", i), 64'(wb_data), 64'(tbl[i].e_wd));
        chk($sformatf("t%0d_wb_rd", i), 64'(wb_rd), 64'(tbl[i].e_rd));
        chk($sformatf("t%0d_wb_dbz", i), 64'(wb_dbz), 64'(tbl[i].e_dz));
      end
    end

    // unit never answers: watchdog must produce a zero writeback after TO WAIT cycles
    mv = -1; wc = -1;
    for (int k = 0; k < 40 && wc < 0; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(1, 1, 3'd3, 32'd9, 32'd9, 5'd2, 0, 0, 0, 0);
      @(negedge clk);
      if (md_valid && mv < 0) begin
        mv = k;
        chk("to_err_before", 64'(timeout_err), 0);
      end
      if (wb_valid) begin
        wc = k;
        chk("to_wb_data", 64'(wb_data), 0);
        chk("to_wb_dbz", 64'(wb_dbz), 0);
        chk("to_wb_rd", 64'(wb_rd), 2);
        chk("to_err_set", 64'(timeout_err), 1);
        ex_valid = 0;
      end
    end
    chk("to_latency", 64'(wc - mv), 64'(TO + 1));
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 64'(timeout_err), 1);

    // asynchronous reset in the middle of WAIT
    @(posedge clk); #1;
    drive(1, 1, 3'd0, 32'd7, 32'd7, 5'd5, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_stall", 64'(stall), 1);
    chk("pre_rst_err", 64'(timeout_err), 1);
    ex_valid = 0;
    rst = 1'b1;
    #1;
    chk("arst_md_a", 64'(md_a), 0);         chk("arst_md_b", 64'(md_b), 0);
    chk("arst_md_op", 64'(md_op), 0);       chk("arst_wb_rd", 64'(wb_rd), 0);
    chk("arst_wb_data", 64'(wb_data), 0);   chk("arst_err", 64'(timeout_err), 0);
    chk("arst_stall", 64'(stall), 0);       chk("arst_md_valid", 64'(md_valid), 0);
    chk("arst_wb_valid", 64'(wb_valid), 0);
    @(negedge clk); rst = 1'b0;

    // fresh MUL 3*5 after reset, unit answers two cycles after the request pulse
    mv = -1; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(1, 1, 3'd0, 32'd3, 32'd5, 5'd7, 0, 0, 0, 0);
      md_done = (mv >= 0 && k == mv + 2);
      md_result = md_done ? 32'd15 : 32'd0;
      @(negedge clk);
      if (md_valid && mv < 0) mv = k;
      if (wb_valid) begin
        got = 1;
        chk("mul35_wb_data", 64'(wb_data), 15);
        chk("mul35_wb_rd", 64'(wb_rd), 7);
        ex_valid = 0;
      end
    end
    chk("mul35_wb_seen", 64'(got), 1);

    // randomized traffic against the transaction model
    m_cap = 0; m_out = 0; m_doom = 0; m_wb = 0; m_terr = 0; m_t = 0;
    m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_res = 0; m_dz = 0; m_wd = 0; m_wdz = 0;
    udue = -1; ures = 0; udz = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ex_valid = ($urandom % 10) < 7;
      ex_is_muldiv = 1'($urandom % 2);
      ex_op = 3'($urandom);
      ex_rs1 = rnd_opnd();
      ex_rs2 = ($urandom % 6 == 0) ? 32'd0 : rnd_opnd();
      ex_rd = 5'($urandom);
      flush = ($urandom % 14) == 0;
      md_done = (c == udue);
      md_result = md_done ? ures : $urandom;
      md_div_by_zero = md_done ? udz : 1'($urandom % 2);
      @(negedge clk);
      m_req = ex_valid & ex_is_muldiv & ~flush;
      m_idle = !m_cap && !m_out && !m_wb;
      e_stall = (m_idle && m_req) || m_cap || (m_out && (!m_doom || (ex_valid && ex_is_muldiv)));
      chk("r_stall", 64'(stall), 64'(e_stall));
      chk("r_md_valid", 64'(md_valid), 64'(m_cap));
      chk("r_wb_valid", 64'(wb_valid), 64'(m_wb && !flush));
      chk("r_timeout_err", 64'(timeout_err), 64'(m_terr));
      if (m_cap) begin
        chk("r_md_a", 64'(md_a), 64'(m_a));
        chk("r_md_b", 64'(md_b), 64'(m_b));
        chk("r_md_op", 64'(md_op), 64'(m_op));
      end
      if (m_wb && !flush) begin
        chk("r_wb_data", 64'(wb_data), 64'(m_wd));
        chk("r_wb_dbz", 64'(wb_dbz), 64'(m_wdz));
        chk("r_wb_rd", 64'(wb_rd), 64'(m_rd));
      end
      if (md_done) udue = -1;
      if (m_wb) m_wb = 0;
      else if (m_cap) begin
        // the fake unit computes from what the DUT actually presented
        {udz, ures} = ref_md(md_op, md_a, md_b);
        lat = ($urandom % 8 == 0) ? 50 : 1 + int'($urandom % (TO + 2));
        udue = c + lat;
        m_cap = 0; m_out = 1; m_doom = flush; m_t = 0;
      end else if (m_out) begin
        if (md_done) begin
          m_out = 0;
          if (!m_doom && !flush) begin m_wb = 1; m_wd = m_res; m_wdz = m_dz; end
        end else if (flush && !m_doom) begin
          m_doom = 1; m_t = 0;
        end else if (m_t == TO - 1) begin
          m_out = 0; m_terr = 1; udue = -1;
          if (!m_doom) begin m_wb = 1; m_wd = 0; m_wdz = 0; end
        end else m_t++;
      end else if (m_req) begin
        m_cap = 1; m_op = ex_op; m_a = ex_rs1; m_b = ex_rs2; m_rd = ex_rd;
        {m_dz, m_res} = ref_md(ex_op, ex_rs1, ex_rs2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
